// File: rtl/serial_link_ddr_rx_pkg.sv
// Shared definitions for the DDR serial link (receive and transmit sides).
//   rx_state_e   : receiver FSM states
//   beat_cnt_t   : beat counter type for the default lane/word geometry
//   *_DEF        : default lane count and word width shared by both link ends
package serial_link_pkg;

  localparam int unsigned NUM_LANES_DEF = 4;
  localparam int unsigned WORD_W_DEF    = 32;
  localparam int unsigned BEATS_DEF     = WORD_W_DEF / NUM_LANES_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  typedef logic [$clog2(BEATS_DEF)-1:0] beat_cnt_t;

endpackage

// File: rtl/serial_link_ddr_rx_if.sv
// Valid/ready word port between the DDR link receiver and the SoC.
//   data_o  : FIFO head word (receiver -> consumer)
//   valid_o : data_o holds a word (receiver -> consumer)
//   ready_i : consumer accepts data_o (consumer -> receiver)
interface serial_link_ddr_rx_if
  import serial_link_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_W_DEF
) ();

  logic [WORD_W-1:0] data_o;
  logic              valid_o;
  logic              ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);

endinterface

// File: rtl/serial_link_ddr_rx_fifo.sv
// First-word fall-through word FIFO for the DDR link receiver.
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   push_i/push_data_i : write request and word
//   pop_i        : consumer handshake (ignored while empty)
//   data_o/valid_o : head word, zero while empty
//   empty_o/full_o : flags registered from the next occupancy count
//   drop_o       : push refused because full with no same-cycle pop
module serial_link_rx_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_n;
  logic             empty_q, full_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && !empty_q;
    // A pop in the same cycle frees the slot a full FIFO needs.
    do_push = push_i && (!full_q || do_pop);
    drop_o  = push_i && full_q && !do_pop;
    count_n = count;
    if (do_push && !do_pop)
      count_n = count + 1'b1;
    else if (!do_push && do_pop)
      count_n = count - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (do_push)
      mem[wr_ptr] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_n;
      empty_q <= (count_n == '0);
      full_q  <= (count_n == (AW+1)'(DEPTH));
    end
  end

  assign data_o  = empty_q ? '0 : mem[rd_ptr];
  assign valid_o = !empty_q;
  assign empty_o = empty_q;
  assign full_o  = full_q;

endmodule

// File: rtl/serial_link_ddr_rx.sv
// Receive end of the 4-lane DDR serial link. Oversamples the lanes and the
// forwarded clock in clk_i, captures one beat per forwarded-clock edge (both
// polarities), packs beats LSB-first into words and buffers them in a FWFT FIFO.
//   clk_i/rst_ni    : system clock, asynchronous active-low reset
//   en_i            : receiver enable
//   ddr_i           : link data lanes
//   ddr_rcv_clk_i   : forwarded link clock (<= clk_i/4)
//   rx_if           : valid/ready word port toward the SoC
//   fifo_empty_o/fifo_full_o : FIFO flags
//   overflow_o      : sticky word-dropped flag, cleared by overflow_clr_i
//   frame_err_o     : 1-cycle pulse when a frame ends with a partial word
module serial_link_ddr_rx
  import serial_link_pkg::*;
#(
  parameter int unsigned NUM_LANES    = NUM_LANES_DEF,
  parameter int unsigned WORD_W       = WORD_W_DEF,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [NUM_LANES-1:0] ddr_i,
  input  logic                 ddr_rcv_clk_i,
  serial_link_ddr_rx_if.master rx_if,
  output logic                 fifo_empty_o,
  output logic                 fifo_full_o,
  output logic                 overflow_o,
  input  logic                 overflow_clr_i,
  output logic                 frame_err_o
);

  localparam int unsigned BEATS = WORD_W / NUM_LANES;
  localparam int unsigned BW    = $clog2(BEATS);
  localparam int unsigned IW    = $clog2(IDLE_TIMEOUT + 1);

  logic [NUM_LANES-1:0] ddr_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                 clk_q;
  logic                 clk_s, edge_det;
  logic [NUM_LANES-1:0] beat_s;

  rx_state_e            state_q;
  logic [BW-1:0]        beat_cnt;
  logic [IW-1:0]        idle_cnt;
  logic [WORD_W-1:0]    word_q, push_word;
  logic                 last_beat, push, drop;
  logic                 frame_err_q, overflow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++)
        ddr_sync[i] <= '0;
      clk_sync <= '0;
      clk_q    <= 1'b0;
    end else begin
      ddr_sync[0] <= ddr_i;
      clk_sync[0] <= ddr_rcv_clk_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        ddr_sync[i] <= ddr_sync[i-1];
        clk_sync[i] <= clk_sync[i-1];
      end
      clk_q <= clk_s;
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign beat_s   = ddr_sync[SYNC_STAGES-1];
  assign edge_det = clk_s ^ clk_q;

  // The final beat is merged combinationally so the word is pushed in the
  // same cycle its last edge is detected.
  always_comb begin
    last_beat = (beat_cnt == BW'(BEATS - 1));
    push      = en_i && (state_q == RECV) && edge_det && last_beat;
    push_word = word_q;
    push_word[(BEATS-1)*NUM_LANES +: NUM_LANES] = beat_s;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      beat_cnt    <= '0;
      idle_cnt    <= '0;
      word_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (!en_i) begin
        state_q  <= IDLE;
        beat_cnt <= '0;
        idle_cnt <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (edge_det) begin
              word_q[NUM_LANES-1:0] <= beat_s;
              beat_cnt <= BW'(1);
              idle_cnt <= '0;
              state_q  <= RECV;
            end
          end
          RECV: begin
            if (edge_det) begin
              word_q[beat_cnt*NUM_LANES +: NUM_LANES] <= beat_s;
              beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
              idle_cnt <= '0;
            end else if (idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
              frame_err_q <= (beat_cnt != '0);
              beat_cnt    <= '0;
              idle_cnt    <= '0;
              state_q     <= IDLE;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      overflow_q <= 1'b0;
    else if (drop)
      overflow_q <= 1'b1;
    else if (overflow_clr_i)
      overflow_q <= 1'b0;
  end

  serial_link_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (rx_if.ready_i),
    .data_o      (rx_if.data_o),
    .valid_o     (rx_if.valid_o),
    .empty_o     (fifo_empty_o),
    .full_o      (fifo_full_o),
    .drop_o      (drop)
  );

  assign overflow_o  = overflow_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_serial_link_ddr_rx.sv
module tb_serial_link_ddr_rx;

  logic       clk_gen = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] ddr;
  logic       rcv_clk;
  logic       fifo_empty, fifo_full, overflow, overflow_clr, frame_err;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_link_ddr_rx_if #(.WORD_W(32)) rx_if ();

  serial_link_ddr_rx #(
    .NUM_LANES    (4),
    .WORD_W       (32),
    .FIFO_DEPTH   (8),
    .SYNC_STAGES  (2),
    .IDLE_TIMEOUT (16)
  ) dut (
    .clk_i          (clk_gen),
    .rst_ni         (rst_n),
    .en_i           (en),
    .ddr_i          (ddr),
    .ddr_rcv_clk_i  (rcv_clk),
    .rx_if          (rx_if),
    .fifo_empty_o   (fifo_empty),
    .fifo_full_o    (fifo_full),
    .overflow_o     (overflow),
    .overflow_clr_i (overflow_clr),
    .frame_err_o    (frame_err)
  );

  always #5 clk_gen = ~clk_gen;

  // Passive monitor: records every accepted word, valid cycles and error pulses.
  logic [31:0] popped [$];
  int          vcnt = 0;
  int          ferr_cnt = 0;

  always @(posedge clk_gen) begin
    if (rx_if.valid_o) vcnt++;
    if (rx_if.valid_o && rx_if.ready_i) popped.push_back(rx_if.data_o);
    if (frame_err) ferr_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no end, want summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_gen);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // One beat per forwarded-clock toggle, forwarded clock at clk/8.
  task automatic send_beat(input logic [3:0] nib);
    ddr     = nib;
    rcv_clk = ~rcv_clk;
    repeat (4) tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] nb;
      nb = w[k*4 +: 4];
      send_beat(nb);
    end
  endtask

  task automatic drain();
    rx_if.ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (fifo_empty) break;
    end
    rx_if.ready_i = 1'b0;
    check("drain_done", 32'(fifo_empty), 32'd1);
  endtask

  function automatic logic [31:0] word_n(input int i);
    return 32'h9E3C_7A10 ^ (32'(i) * 32'h0110_1011);
  endfunction

  initial begin
    int base;
    int fbase;
    logic [31:0] w;
    logic [3:0]  nb;

    rst_n = 1'b0;
    en = 1'b1;
    ddr = 4'h0;
    rcv_clk = 1'b0;
    overflow_clr = 1'b0;
    rx_if.ready_i = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_data", rx_if.data_o, 32'h0);
    check("rst_valid", 32'(rx_if.valid_o), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: nibbles 1..8, latency of the last beat
    for (int k = 1; k < 8; k++) send_beat(4'(k));
    ddr = 4'h8;
    rcv_clk = ~rcv_clk;      // pin edge just after posedge P0
    tick();                  // P1: first sync flop
    tick();                  // P2: second sync flop, edge-detect cycle follows
    check("t1_valid_early", 32'(rx_if.valid_o), 32'd0);
    tick();                  // P3: word pushed
    check("t1_valid", 32'(rx_if.valid_o), 32'd1);
    check("t1_data", rx_if.data_o, 32'h8765_4321);
    check("t1_empty", 32'(fifo_empty), 32'd0);
    drain();

    // 2: three back-to-back words with ready high
    base = popped.size();
    vcnt = 0;
    fbase = ferr_cnt;
    rx_if.ready_i = 1'b1;
    send_word(32'hDEAD_BEEF);
    send_word(32'h0123_4567);
    send_word(32'hF0E1_D2C3);
    repeat (6) tick();
    rx_if.ready_i = 1'b0;
    check("t2_count", 32'(popped.size() - base), 32'd3);
    check("t2_w0", popped[base], 32'hDEAD_BEEF);
    check("t2_w1", popped[base+1], 32'h0123_4567);
    check("t2_w2", popped[base+2], 32'hF0E1_D2C3);
    check("t2_single_cycle", 32'(vcnt), 32'd3);
    check("t2_empty", 32'(fifo_empty), 32'd1);
    check("t2_no_ferr", 32'(ferr_cnt - fbase), 32'd0);

    // 3: partial frame of 5 beats, then timeout
    fbase = ferr_cnt;
    base = popped.size();
    for (int k = 0; k < 5; k++) send_beat(4'(k + 10));
    repeat (20) tick();
    check("t3_ferr_once", 32'(ferr_cnt - fbase), 32'd1);
    check("t3_no_push", 32'(fifo_empty), 32'd1);
    rx_if.ready_i = 1'b1;
    send_word(32'hCAFE_F00D);
    repeat (6) tick();
    rx_if.ready_i = 1'b0;
    check("t3_count", 32'(popped.size() - base), 32'd1);
    check("t3_word", popped[base], 32'hCAFE_F00D);
    check("t3_ferr_still_once", 32'(ferr_cnt - fbase), 32'd1);

    // 4: overflow with ready low
    base = popped.size();
    for (int i = 0; i < 8; i++) send_word(word_n(i));
    check("t4_full", 32'(fifo_full), 32'd1);
    check("t4_ovf_before", 32'(overflow), 32'd0);
    send_word(word_n(8));
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_full_after", 32'(fifo_full), 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'd0);
    drain();
    check("t4_count", 32'(popped.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t4_w%0d", i), popped[base+i], word_n(i));

    // 5: push on a full FIFO in the same cycle as a pop
    base = popped.size();
    for (int i = 0; i < 8; i++) send_word(word_n(20 + i));
    check("t5_full", 32'(fifo_full), 32'd1);
    w = word_n(40);
    for (int k = 0; k < 7; k++) begin
      nb = w[k*4 +: 4];
      send_beat(nb);
    end
    nb = w[28 +: 4];
    ddr = nb;
    rcv_clk = ~rcv_clk;
    tick();
    tick();
    rx_if.ready_i = 1'b1;    // pop lands on the push edge P3
    tick();
    rx_if.ready_i = 1'b0;
    check("t5_one_pop", 32'(popped.size() - base), 32'd1);
    check("t5_full_kept", 32'(fifo_full), 32'd1);
    check("t5_no_ovf", 32'(overflow), 32'd0);
    drain();
    check("t5_count", 32'(popped.size() - base), 32'd9);
    for (int i = 0; i < 8; i++) check($sformatf("t5_w%0d", i), popped[base+i], word_n(20 + i));
    check("t5_new", popped[base+8], w);

    // 6a: reset after beat 4
    fbase = ferr_cnt;
    base = popped.size();
    for (int k = 0; k < 4; k++) send_beat(4'(k + 3));
    rst_n = 1'b0;
    rcv_clk = 1'b0;
    tick();
    tick();
    check("t6a_rst_valid", 32'(rx_if.valid_o), 32'd0);
    check("t6a_rst_empty", 32'(fifo_empty), 32'd1);
    rst_n = 1'b1;
    tick();
    rx_if.ready_i = 1'b1;
    send_word(word_n(50));
    repeat (6) tick();
    rx_if.ready_i = 1'b0;
    check("t6a_count", 32'(popped.size() - base), 32'd1);
    check("t6a_word", popped[base], word_n(50));
    check("t6a_no_ferr", 32'(ferr_cnt - fbase), 32'd0);

    // 6b: enable dropped after beat 4
    fbase = ferr_cnt;
    base = popped.size();
    for (int k = 0; k < 4; k++) send_beat(4'(k + 9));
    en = 1'b0;
    repeat (25) tick();
    check("t6b_no_ferr", 32'(ferr_cnt - fbase), 32'd0);
    check("t6b_empty", 32'(fifo_empty), 32'd1);
    en = 1'b1;
    tick();
    rx_if.ready_i = 1'b1;
    send_word(word_n(60));
    repeat (6) tick();
    rx_if.ready_i = 1'b0;
    check("t6b_count", 32'(popped.size() - base), 32'd1);
    check("t6b_word", popped[base], word_n(60));
    check("t6b_no_ferr_end", 32'(ferr_cnt - fbase), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
